// File: rtl/vdp_dram_bridge.sv
// Bridge from the VDP byte-wide VRAM port to the 128-bit DDR3 user bus.
// One request outstanding at a time; an optional one-line read cache short-cuts repeat reads.
module vdp_dram_bridge #(
  parameter int unsigned CACHE_EN       = 1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sdram_init_busy,
  input  logic [16:0]  vdp_address,
  input  logic         vdp_write,
  input  logic         vdp_valid,
  output logic         vdp_ready,
  input  logic [7:0]   vdp_wdata,
  output logic [7:0]   vdp_rdata,
  output logic         vdp_rdata_en,
  output logic [16:0]  dram_address,
  output logic         dram_write,
  output logic         dram_valid,
  input  logic         dram_ready,
  output logic [127:0] dram_wdata,
  output logic [15:0]  dram_wdata_mask,
  input  logic [127:0] dram_rdata,
  input  logic         dram_rdata_en
);

  typedef enum logic [2:0] {StIdle, StHit, StReq, StWaitRd, StDone} state_e;

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

  state_e         state_q, state_d;
  logic           ready_q, ready_d;
  logic [7:0]     rdata_q, rdata_d;
  logic           rdata_en_q, rdata_en_d;
  logic           dvalid_q, dvalid_d;
  logic           dwrite_q, dwrite_d;
  logic [16:0]    daddr_q, daddr_d;
  logic [127:0]   dwdata_q, dwdata_d;
  logic [15:0]    dmask_q, dmask_d;
  logic [12:0]    tag_q, tag_d;
  logic [3:0]     idx_q, idx_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [127:0]   cache_line_q, cache_line_d;
  logic [12:0]    cache_tag_q, cache_tag_d;
  logic           cache_valid_q, cache_valid_d;

  logic accept;
  logic tag_match;

  assign accept    = vdp_valid && ready_q;
  assign tag_match = cache_valid_q && (cache_tag_q == vdp_address[16:4]);

  always_comb begin
    state_d       = state_q;
    rdata_d       = rdata_q;
    rdata_en_d    = 1'b0;
    dvalid_d      = dvalid_q;
    dwrite_d      = dwrite_q;
    daddr_d       = daddr_q;
    dwdata_d      = dwdata_q;
    dmask_d       = dmask_q;
    tag_d         = tag_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    cache_line_d  = cache_line_q;
    cache_tag_d   = cache_tag_q;
    cache_valid_d = cache_valid_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          tag_d = vdp_address[16:4];
          idx_d = vdp_address[3:0];
          if (vdp_write) begin
            state_d  = StReq;
            dvalid_d = 1'b1;
            dwrite_d = 1'b1;
            daddr_d  = {vdp_address[16:4], 4'h0};
            dwdata_d = {16{vdp_wdata}};
            dmask_d  = ~(16'h0001 << vdp_address[3:0]);
            // Write-through keeps the cached line coherent with DRAM.
            if (tag_match) begin
              cache_line_d[{vdp_address[3:0], 3'b000} +: 8] = vdp_wdata;
            end
          end else if ((CACHE_EN != 0) && tag_match) begin
            // Strobe is registered so it appears while the FSM sits in StHit.
            state_d    = StHit;
            rdata_d    = cache_line_q[{vdp_address[3:0], 3'b000} +: 8];
            rdata_en_d = 1'b1;
          end else begin
            state_d  = StReq;
            dvalid_d = 1'b1;
            dwrite_d = 1'b0;
            daddr_d  = {vdp_address[16:4], 4'h0};
            dmask_d  = 16'hFFFF;
          end
        end
      end
      StHit: state_d = StIdle;
      StReq: begin
        if (dram_ready) begin
          dvalid_d = 1'b0;
          cnt_d    = 8'd0;
          state_d  = dwrite_q ? StIdle : StWaitRd;
        end
      end
      StWaitRd: begin
        // Data arriving on the timeout cycle takes priority.
        if (dram_rdata_en) begin
          rdata_d    = dram_rdata[{idx_q, 3'b000} +: 8];
          rdata_en_d = 1'b1;
          state_d    = StDone;
          if (CACHE_EN != 0) begin
            cache_line_d  = dram_rdata;
            cache_tag_d   = tag_q;
            cache_valid_d = 1'b1;
          end
        end else if (cnt_q == TimeoutLast) begin
          cache_valid_d = 1'b0;
          rdata_d       = 8'hFF;
          rdata_en_d    = 1'b1;
          state_d       = StDone;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (sdram_init_busy) begin
      cache_valid_d = 1'b0;
    end

    ready_d = (state_d == StIdle) && !sdram_init_busy;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      ready_q       <= 1'b0;
      rdata_q       <= 8'h00;
      rdata_en_q    <= 1'b0;
      dvalid_q      <= 1'b0;
      dwrite_q      <= 1'b0;
      daddr_q       <= 17'h0;
      dwdata_q      <= 128'h0;
      dmask_q       <= 16'hFFFF;
      tag_q         <= 13'h0;
      idx_q         <= 4'h0;
      cnt_q         <= 8'h0;
      cache_line_q  <= 128'h0;
      cache_tag_q   <= 13'h0;
      cache_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ready_q       <= ready_d;
      rdata_q       <= rdata_d;
      rdata_en_q    <= rdata_en_d;
      dvalid_q      <= dvalid_d;
      dwrite_q      <= dwrite_d;
      daddr_q       <= daddr_d;
      dwdata_q      <= dwdata_d;
      dmask_q       <= dmask_d;
      tag_q         <= tag_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      cache_line_q  <= cache_line_d;
      cache_tag_q   <= cache_tag_d;
      cache_valid_q <= cache_valid_d;
    end
  end

  assign vdp_ready       = ready_q;
  assign vdp_rdata       = rdata_q;
  assign vdp_rdata_en    = rdata_en_q;
  assign dram_address    = daddr_q;
  assign dram_write      = dwrite_q;
  assign dram_valid      = dvalid_q;
  assign dram_wdata      = dwdata_q;
  assign dram_wdata_mask = dmask_q;

endmodule
